// File: rtl/raster_multi.sv
`default_nettype none
// ============================================================================
// Module   : raster_multi
// Brief    : Per-pixel coverage of NUM_TRI triangles with lowest-index
//            priority, flat shading and texel address output. The optional
//            back-face coverage is enabled with macro RASTER_BACKFACE_EN.
// Revision : 1.0
// ============================================================================
module raster_multi #(
    parameter int NUM_TRI  = 4,
    parameter int EW       = 20,
    parameter int BW       = 22,
    parameter int CW       = 6,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [NUM_TRI*3*EW-1:0] e_init,
    input  logic [NUM_TRI*3*EW-1:0] e_dx,
    input  logic [NUM_TRI*2*BW-1:0] b_init,
    input  logic [NUM_TRI*2*BW-1:0] b_dx,
    input  logic [NUM_TRI*CW-1:0]   tri_color,
    input  logic [CW-1:0]           bg_color,
    output logic [CW-1:0]           rgb,
    output logic                    hit,
    output logic [2:0]              tri_id,
    output logic                    back,
    output logic [6:0]              u,
    output logic [6:0]              v
);
    localparam logic [9:0] c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
    localparam int         c_NE       = NUM_TRI * 3;
    localparam int         c_NB       = NUM_TRI * 2;

    typedef enum logic [0:0] {
        S_EVAL  = 1'b0,
        S_SHADE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_NE-1:0][EW-1:0] r_e;
    logic [c_NE-1:0][EW-1:0] w_e_next;
    logic [c_NB-1:0][BW-1:0] r_b;
    logic [c_NB-1:0][BW-1:0] w_b_next;
    logic [NUM_TRI-1:0]      w_front;
    logic [NUM_TRI-1:0]      w_backf;
    logic                    w_cov;
    logic                    w_win_back;
    logic [2:0]              w_win;
    logic [BW-3:0]           w_by_win;
    logic [BW-3:0]           w_bz_win;
    logic [BW-3:0]           w_uv_sum;
    logic                    w_unused;
    logic [CW-1:0]           w_win_color;
    logic                    w_active;
    logic                    w_reload;

    logic                    r_win_cov;
    logic                    r_win_back;
    logic [2:0]              r_win_id;
    logic [CW-1:0]           r_rgb;
    logic                    r_hit;
    logic [2:0]              r_tri_id;
    logic                    r_back;
    logic [6:0]              r_u;
    logic [6:0]              r_v;

    assign w_active = (x < c_H_ACTIVE) && (y < c_V_ACTIVE);
    assign w_reload = (x == c_H_LAST) && ((y < c_V_ACTIVE) || (y == c_V_LAST));

    generate
        for (genvar i = 0; i < c_NE; i++) begin : g_edge
            assign w_e_next[i] = r_e[i] + e_dx[i*EW +: EW];
        end
        for (genvar i = 0; i < c_NB; i++) begin : g_bary
            assign w_b_next[i] = r_b[i] + b_dx[i*BW +: BW];
        end
        for (genvar t = 0; t < NUM_TRI; t++) begin : g_tri
            // Zero is neither negative nor positive, so it never counts as inside.
            assign w_front[t] = r_e[t*3][EW-1] & r_e[t*3+1][EW-1] & r_e[t*3+2][EW-1];
`ifdef RASTER_BACKFACE_EN
            assign w_backf[t] = (~r_e[t*3][EW-1]   & (|r_e[t*3]))
                              & (~r_e[t*3+1][EW-1] & (|r_e[t*3+1]))
                              & (~r_e[t*3+2][EW-1] & (|r_e[t*3+2]));
`else
            assign w_backf[t] = 1'b0;
`endif
        end
    endgenerate

    // Descending scan so the lowest covering index is the last one written.
    always_comb begin
        w_cov      = 1'b0;
        w_win      = 3'd0;
        w_win_back = 1'b0;
        w_by_win   = '0;
        w_bz_win   = '0;
        for (int t = NUM_TRI - 1; t >= 0; t--) begin
            if (w_front[t] || w_backf[t]) begin
                w_cov      = 1'b1;
                w_win      = 3'(t);
                w_win_back = ~w_front[t];
                w_by_win   = w_b_next[t*2][BW-3:0];
                w_bz_win   = w_b_next[t*2+1][BW-3:0];
            end
        end
    end

    assign w_uv_sum = w_by_win + w_bz_win;
    assign w_unused = ^w_uv_sum[BW-10:0];

    always_comb begin
        w_win_color = bg_color;
        for (int t = 0; t < NUM_TRI; t++) begin
            if (r_win_cov && (r_win_id == 3'(t))) begin
                w_win_color = tri_color[t*CW +: CW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e        <= '0;
            r_b        <= '0;
            r_state    <= S_SHADE;
            r_win_cov  <= 1'b0;
            r_win_back <= 1'b0;
            r_win_id   <= 3'd0;
            r_rgb      <= '0;
            r_hit      <= 1'b0;
            r_tri_id   <= 3'd0;
            r_back     <= 1'b0;
            r_u        <= 7'd0;
            r_v        <= 7'd0;
        end else if (w_reload) begin
            r_e <= e_init;
            r_b <= b_init;
        end else if (w_active) begin
            if (r_state == S_EVAL) begin
                r_b        <= w_b_next;
                r_win_cov  <= w_cov;
                r_win_id   <= w_win;
                r_win_back <= w_win_back;
                if (w_cov) begin
                    r_u <= w_bz_win[BW-3:BW-9];
                    r_v <= w_uv_sum[BW-3:BW-9];
                end
                r_state <= S_SHADE;
            end else begin
                r_e      <= w_e_next;
                r_rgb    <= w_win_color;
                r_hit    <= r_win_cov;
                r_tri_id <= r_win_cov ? r_win_id : 3'd0;
                r_back   <= r_win_cov & r_win_back;
                r_state  <= S_EVAL;
            end
        end
    end

    assign rgb    = r_rgb;
    assign hit    = r_hit;
    assign tri_id = r_tri_id;
    assign back   = r_back;
    assign u      = r_u;
    assign v      = r_v;

endmodule
`default_nettype wire

// File: tb/tb_raster_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_multi
// Brief    : Directed scoreboard bench for raster_multi (NUM_TRI=4 defaults).
// Revision : 1.0
// ============================================================================
module tb_raster_multi;
    localparam int NT = 4;
    localparam int EW = 20;
    localparam int BW = 22;
    localparam int CW = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         x;
    logic [9:0]         y;
    logic [NT*3*EW-1:0] e_init;
    logic [NT*3*EW-1:0] e_dx;
    logic [NT*2*BW-1:0] b_init;
    logic [NT*2*BW-1:0] b_dx;
    logic [NT*CW-1:0]   tri_color;
    logic [CW-1:0]      bg_color;
    logic [CW-1:0]      rgb;
    logic               hit;
    logic [2:0]         tri_id;
    logic               back;
    logic [6:0]         u;
    logic [6:0]         v;

    always #5 clk = ~clk;

    raster_multi #(
        .NUM_TRI(NT),
        .EW     (EW),
        .BW     (BW),
        .CW     (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .e_init   (e_init),
        .e_dx     (e_dx),
        .b_init   (b_init),
        .b_dx     (b_dx),
        .tri_color(tri_color),
        .bg_color (bg_color),
        .rgb      (rgb),
        .hit      (hit),
        .tri_id   (tri_id),
        .back     (back),
        .u        (u),
        .v        (v)
    );

    typedef struct packed {
        logic [5:0] rgb;
        logic       hit;
        logic [2:0] id;
        logic       back;
        logic [6:0] u;
        logic [6:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_n  = 0;
    logic present = 1'b0;
    logic chk     = 1'b0;
    exp_t m_act;
    exp_t m_exp;

    // present marks the cycle whose closing edge performs a SHADE (or reset).
    always @(posedge clk) chk <= present;

    always @(negedge clk) begin
        if (chk) begin
            m_act  = exp_t'({rgb, hit, tri_id, back, u, v});
            checks = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pixel%0d: output with no queued expectation, actual rgb=%h hit=%b id=%0d",
                         mon_n, rgb, hit, tri_id);
            end else begin
                m_exp = q.pop_front();
                if (m_act !== m_exp) begin
                    errors = errors + 1;
                    $display("FAIL pixel%0d: actual rgb=%h hit=%b id=%0d back=%b u=%0d v=%0d, required rgb=%h hit=%b id=%0d back=%b u=%0d v=%0d",
                             mon_n, m_act.rgb, m_act.hit, m_act.id, m_act.back, m_act.u, m_act.v,
                             m_exp.rgb, m_exp.hit, m_exp.id, m_exp.back, m_exp.u, m_exp.v);
                end
            end
            mon_n = mon_n + 1;
        end
    end

    task automatic cyc(input logic [9:0] xx, input logic [9:0] yy, input logic pres);
        x       = xx;
        y       = yy;
        present = pres;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_px(input logic [5:0] r, input logic h, input logic [2:0] id,
                             input logic bk, input logic [6:0] uu, input logic [6:0] vv);
        q.push_back(exp_t'({r, h, id, bk, uu, vv}));
    endtask

    // One pixel: an EVAL cycle followed by the SHADE cycle that presents it.
    task automatic pixel(input logic [9:0] xx, input logic [9:0] yy);
        cyc(xx, yy, 1'b0);
        cyc(xx, yy, 1'b1);
    endtask

    task automatic set_tri(input int t, input int init, input int dx);
        for (int k = 0; k < 3; k++) begin
            e_init[(t*3+k)*EW +: EW] = EW'(init);
            e_dx[(t*3+k)*EW +: EW]   = EW'(dx);
        end
    endtask

    // Mixed-sign edges: neither front- nor back-inside.
    task automatic set_out(input int t);
        e_init[(t*3)*EW +: EW]   = EW'(5);
        e_init[(t*3+1)*EW +: EW] = EW'(-5);
        e_init[(t*3+2)*EW +: EW] = EW'(5);
        for (int k = 0; k < 3; k++) e_dx[(t*3+k)*EW +: EW] = '0;
    endtask

    task automatic set_b(input int t, input int by_i, input int bz_i, input int by_d, input int bz_d);
        b_init[(t*2)*BW +: BW]   = BW'(by_i);
        b_init[(t*2+1)*BW +: BW] = BW'(bz_i);
        b_dx[(t*2)*BW +: BW]     = BW'(by_d);
        b_dx[(t*2+1)*BW +: BW]   = BW'(bz_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        x         = 10'd0;
        y         = 10'd0;
        e_init    = '0;
        e_dx      = '0;
        b_init    = '0;
        b_dx      = '0;
        tri_color = {6'h33, 6'h22, 6'h1F, 6'h01};
        bg_color  = 6'h15;
        for (int t = 0; t < NT; t++) set_tri(t, 5, 0);
        repeat (3) cyc(10'd0, 10'd0, 1'b0);

        checks = checks + 1;
        if ({rgb, hit, tri_id, back, u, v} !== 25'd0) begin
            errors = errors + 1;
            $display("FAIL reset_state: actual rgb=%h hit=%b id=%0d back=%b u=%0d v=%0d, required all 0",
                     rgb, hit, tri_id, back, u, v);
        end

        // First active cycle after reset is SHADE with nothing covered.
        reset = 1'b0;
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd0, 7'd0);
        cyc(10'd0, 10'd0, 1'b1);

        // Triangle 2 edges -3,+1 per pixel: inside for x=0..2 only.
        set_out(0); set_out(1); set_out(3);
        set_tri(2, -3, 1);
        cyc(10'd799, 10'd1, 1'b0);
        for (int n = 0; n < 3; n++) expect_px(6'h22, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0);
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd0, 7'd0);
`ifdef RASTER_BACKFACE_EN
        expect_px(6'h22, 1'b1, 3'd2, 1'b1, 7'd0, 7'd0);
`else
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd0, 7'd0);
`endif
        for (int n = 0; n < 5; n++) pixel(10'(n), 10'd2);

        // Triangles 1 and 3 both cover; 1 wins and supplies u/v.
        set_out(0); set_out(2);
        set_tri(1, -1, 0);
        set_tri(3, -1, 0);
        set_b(1, 10 << 13, 5 << 13, 0, 1 << 13);
        set_b(3, 0, 40 << 13, 0, 0);
        cyc(10'd799, 10'd2, 1'b0);
        expect_px(6'h1F, 1'b1, 3'd1, 1'b0, 7'd6, 7'd16);
        expect_px(6'h1F, 1'b1, 3'd1, 1'b0, 7'd7, 7'd17);
        pixel(10'd0, 10'd3);
        pixel(10'd1, 10'd3);

        // Triangle 0 all edges +4.
        set_tri(0, 4, 0);
        set_out(1); set_out(2); set_out(3);
        set_b(0, 0, 0, 0, 0);
        cyc(10'd799, 10'd3, 1'b0);
`ifdef RASTER_BACKFACE_EN
        expect_px(6'h01, 1'b1, 3'd0, 1'b1, 7'd0, 7'd0);
`else
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd7, 7'd17);
`endif
        pixel(10'd0, 10'd4);

        // u steps by one per pixel and wraps; edges reach 0 after 130 pixels.
        set_tri(0, -130, 1);
        set_b(0, 0, 0, 0, 1 << 13);
        cyc(10'd799, 10'd9, 1'b0);
        for (int n = 0; n < 130; n++) begin
            expect_px(6'h01, 1'b1, 3'd0, 1'b0, 7'((n + 1) % 128), 7'((n + 1) % 128));
            pixel(10'(n), 10'd10);
        end
        cyc(10'd799, 10'd10, 1'b0);
        expect_px(6'h01, 1'b1, 3'd0, 1'b0, 7'd1, 7'd1);
        pixel(10'd0, 10'd11);

        // Mid-line reset, then frame reload restores the init values.
        expect_px(6'h00, 1'b0, 3'd0, 1'b0, 7'd0, 7'd0);
        reset = 1'b1;
        cyc(10'd320, 10'd11, 1'b1);
        reset = 1'b0;
        set_tri(0, -2, 1);
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd0, 7'd0);
        cyc(10'd0, 10'd0, 1'b1);
        cyc(10'd799, 10'd524, 1'b0);
        expect_px(6'h01, 1'b1, 3'd0, 1'b0, 7'd1, 7'd1);
        expect_px(6'h01, 1'b1, 3'd0, 1'b0, 7'd2, 7'd2);
        expect_px(6'h15, 1'b0, 3'd0, 1'b0, 7'd2, 7'd2);
        for (int n = 0; n < 3; n++) pixel(10'(n), 10'd0);

        cyc(10'd700, 10'd0, 1'b0);
        cyc(10'd700, 10'd0, 1'b0);

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: actual %0d expectations left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/raster_multi.md
RASTER_MULTI -- requirements
Module: raster_multi

Interface
REQ-001 Parameter NUM_TRI, default 4: number of triangles tested per pixel, range 1..8.
REQ-002 Parameter EW, default 20: signed edge-function width.
REQ-003 Parameter BW, default 22: signed barycentric width, Q2.(BW-2).
REQ-004 Parameter CW, default 6: colour width.
REQ-005 Parameters H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL, defaults 640/800/480/525: scan timing.
REQ-006 Port clk, input, 1: clock; reset, input, 1: reset, synchronous, active-high.
REQ-007 Port x, input, 10: VGA column. Port y, input, 10: VGA row.
REQ-008 Port e_init, input, NUM_TRI*3*EW: per-line edge start values; slice t*3+k is edge k of triangle t.
REQ-009 Port e_dx, input, NUM_TRI*3*EW: per-pixel edge increments, same packing as e_init.
REQ-010 Port b_init, input, NUM_TRI*2*BW: per-line barycentrics; slice t*2 is b_y and slice t*2+1 is b_z of triangle t.
REQ-011 Port b_dx, input, NUM_TRI*2*BW: per-pixel barycentric increments, same packing as b_init.
REQ-012 Port tri_color, input, NUM_TRI*CW: flat colour per triangle. Port bg_color, input, CW: background colour.
REQ-013 Port rgb, output, CW: pixel colour. Port hit, output, 1: a triangle covers the pixel.
REQ-014 Port tri_id, output, 3: winning triangle index. Port back, output, 1: winner is back-facing.
REQ-015 Port u, output, 7 and port v, output, 7: texel address of the winner, for an external ROM.

Function
REQ-016 Each active pixel takes two clocks, run by a state machine EVAL -> SHADE -> EVAL; the state machine advances only while x<H_ACTIVE and y<V_ACTIVE.
REQ-017 EVAL: for every t, b_y[t] <= b_y[t]+b_dx_y[t] and b_z[t] <= b_z[t]+b_dx_z[t].
REQ-018 EVAL: triangle t is front-inside when all 3 edges are <0, using the edge values as held before this EVAL.
REQ-019 EVAL: the winner is the lowest-index covering triangle; the winner's index and facing are registered internally.
REQ-020 EVAL: u and v are taken from the winner's updated barycentrics: u=b_z'[BW-3:BW-9] and v=(b_y'+b_z')[BW-3:BW-9].
REQ-021 SHADE: rgb <= tri_color[winner] if covered, else bg_color; hit, tri_id and back update in the same cycle as rgb.
REQ-022 SHADE: every edge register e[t][k] <= e[t][k]+e_dx[t][k].
REQ-023 The rgb latency from the EVAL of pixel n to valid rgb is exactly 1 clock (the following SHADE cycle).
REQ-024 An edge value of exactly 0 never counts as inside.
REQ-025 All sums wrap modulo 2^EW or 2^BW; no saturation.
REQ-026 Line reload happens at y<V_ACTIVE and x==H_TOTAL-1: all e <= e_init and all b <= b_init.
REQ-027 Frame reload happens at y==V_TOTAL-1 and x==H_TOTAL-1: all e <= e_init and all b <= b_init.
REQ-028 Outside the active area, outputs hold their last value and no accumulator changes except at reloads.
REQ-029 When no triangle is covered: hit=0, tri_id=0, back=0, rgb=bg_color, and u, v hold their previous values.

Reset
REQ-030 On reset, all e and b registers clear to 0.
REQ-031 On reset, rgb, hit, tri_id, back, u and v clear to 0, and the state is SHADE.
REQ-032 Reset asserted mid-line takes priority over every update; after reset the first active cycle is SHADE.

Configuration
REQ-033 Macro RASTER_BACKFACE_EN controls back-face coverage.
REQ-034 With RASTER_BACKFACE_EN defined, triangle t is also covered when all 3 edges are >0, with back=1; for each t the front test is checked before the back test, and priority still goes by lowest index.
REQ-035 Without RASTER_BACKFACE_EN, all-positive triangles are culled and back is tied to 0.

Verification
REQ-036 Reset pulse, then NUM_TRI=4, e_init all +5, bg_color=6'h15 -> first SHADE gives rgb=6'h15 and hit=0.
REQ-037 Triangle 2 with e_init=-3 and e_dx=+1, others outside -> hit=1 and tri_id=2 for pixels x=0..2; hit=0 from x=3 on.
REQ-038 Triangles 1 and 3 both covering, tri_color[1]=6'h1F -> rgb=6'h1F and tri_id=1.
REQ-039 Triangle 0 edges +4 with RASTER_BACKFACE_EN defined -> hit=1 and back=1; same stimulus without the macro -> hit=0.
REQ-040 b_dx_z=2^13 and b_init=0 -> u increments by 1 per pixel and wraps from 127 to 0; edge accumulators are reloaded from e_init at x=799.
REQ-041 Reset asserted at x=320 -> all outputs are 0 next cycle; at the next frame reload the accumulators equal the init values.
